// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   This block sits at the consumer end of the functional-unit result
//   handshake (valid_out / out / yumi_in) for the divide, ALU, multiply and
//   load units. Each cycle it selects one pending result using round-robin
//   order and acknowledges it with a one-cycle yumi. The selected packet is
//   registered and broadcast on the common data bus for exactly one cycle.
//   Because the order is round-robin, a slow unit such as the divider is
//   never starved.
//
// Packet layout (CDB_packet_t, MSB to LSB):
//   { dest_ROB_entry[ROB_W-1:0], result[DATA_W-1:0], branch_result, from_memory }
//
// Ports:
//   clk        in   core clock
//   reset_n    in   asynchronous active-low reset
//   fu_valid   in   [NUM_FU]         per-FU result-pending flag
//   fu_packet  in   [NUM_FU][PKT_W]  per-FU result packet
//   fu_yumi    out  [NUM_FU]         per-FU acknowledge, one-hot or zero
//   flush      in   mispredict flush from the ROB
//   cdb_valid  out  registered broadcast valid
//   cdb_out    out  [PKT_W]          registered broadcast packet
//
// Optional feature:
//   CDB_MEM_PRIORITY_EN - when defined, any valid requester whose packet has
//   from_memory set wins over plain round-robin order. Ties among memory
//   requesters are settled by the same round-robin scan. When undefined,
//   arbitration is pure round-robin and from_memory is ignored.
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32,
  localparam int PKT_W = ROB_W + DATA_W + 2,
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][PKT_W-1:0]   fu_packet,
  output logic [NUM_FU-1:0]              fu_yumi,
  input  logic                           flush,
  output logic                           cdb_valid,
  output logic [PKT_W-1:0]               cdb_out
);

  typedef struct packed {
    logic [ROB_W-1:0]  dest_ROB_entry;
    logic [DATA_W-1:0] result;
    logic              branch_result;
    logic              from_memory;
  } cdb_packet_t;

  logic              cdb_valid_q, cdb_valid_d;
  cdb_packet_t       cdb_out_q, cdb_out_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_fire;
  logic [PTR_W-1:0]  grant_next_ptr;

  // Index of the requester 'offset' positions after 'base', wrapping modulo
  // NUM_FU (which need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_FU) sum = sum - NUM_FU;
    return PTR_W'(sum);
  endfunction

  // Scan from rr_ptr upward with wrap-around; the first valid requester wins.
  // Packet contents only influence the scan when gated by fu_valid, so the
  // packets of idle requesters cannot leak into the grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
`ifdef CDB_MEM_PRIORITY_EN
    for (int k = 0; k < NUM_FU; k++) begin
      if (!grant_found && fu_valid[wrap_idx(rr_ptr_q, k)] &&
          fu_packet[wrap_idx(rr_ptr_q, k)][0]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr_q, k);
      end
    end
`endif
    for (int k = 0; k < NUM_FU; k++) begin
      if (!grant_found && fu_valid[wrap_idx(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr_q, k);
      end
    end
  end

  // A flush suppresses the grant for the cycle; requesters keep their results.
  assign grant_fire     = grant_found && !flush;
  assign grant_next_ptr = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;

  // yumi is forced low while in reset so no FU drops a result the arbiter
  // could not capture.
  always_comb begin
    fu_yumi = '0;
    if (grant_fire && reset_n) fu_yumi[grant_idx] = 1'b1;
  end

  // cdb_valid is a pure one-cycle pulse per grant; the packet and pointer
  // hold when nothing is granted.
  always_comb begin
    cdb_valid_d = grant_fire;
    cdb_out_d   = cdb_out_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_fire) begin
      cdb_out_d = cdb_packet_t'(fu_packet[grant_idx]);
      rr_ptr_d  = grant_next_ptr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cdb_valid_q <= 1'b0;
      cdb_out_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_out_q   <= cdb_out_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_out   = cdb_out_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Consumer end of the functional-unit result handshake (`valid_out` / `out` / `yumi_in`) used by the divide, ALU, multiply and load units.
- Each cycle it picks one pending functional-unit result and acknowledges it with a single-cycle yumi.
- The chosen CDB_packet_t is registered and broadcast on the common data bus for exactly one cycle, to the ROB and the reservation stations.
- Arbitration is round-robin, so a long-latency unit such as the divider cannot be starved.

Parameters:
- NUM_FU, 4, number of functional-unit requesters (2..8).
- ROB_W, 4, width of dest_ROB_entry.
- DATA_W, 32, width of result.

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous, active-low reset.
- fu_valid  input  NUM_FU  per-FU result-pending flag (the FU's valid_out).
- fu_packet  input  NUM_FU x CDB_packet_t  per-FU result packet (the FU's out); index i belongs to fu_valid[i].
- fu_yumi  output  NUM_FU  per-FU acknowledge (drives the FU's yumi_in); one-hot or zero.
- flush  input  1  mispredict flush from the ROB.
- cdb_valid  output  1  broadcast valid, registered.
- cdb_out  output  CDB_packet_t  broadcast packet (dest_ROB_entry, result, branch_result, from_memory), registered.

Behaviour:
- Reset (reset_n low, asynchronous):
  - cdb_valid = 0.
  - cdb_out = all zeros.
  - rr_ptr = 0.
  - fu_yumi = 0 combinationally while reset_n is low.
- Grant (combinational, every cycle, flush low):
  - Scan fu_valid starting at index rr_ptr, wrapping modulo NUM_FU.
  - The first set bit is the grant g.
  - fu_yumi[g] = 1; all other bits 0.
  - If no fu_valid bit is set, fu_yumi = 0.
- Capture (posedge clk):
  - On a grant: cdb_out <= fu_packet[g], cdb_valid <= 1, rr_ptr <= (g+1) mod NUM_FU.
  - With no grant: cdb_valid <= 0; cdb_out and rr_ptr hold.
- Latency and throughput:
  - The packet appears on the CDB exactly 1 cycle after its yumi.
  - cdb_valid stays high for exactly 1 cycle per grant.
  - Sustained throughput is 1 packet per cycle.
- Handshake rules:
  - yumi is asserted only to a requester whose fu_valid is high in the same cycle.
  - A requester must hold fu_valid and fu_packet stable until it is yumi'd. The arbiter relies on this and never re-samples an un-granted requester's packet.
  - The FU drops valid the cycle after yumi; the divide unit, for example, returns to idle.
- No downstream backpressure: the CDB always accepts, so nothing is buffered beyond the single output register.
- Flush:
  - When flush is high, fu_yumi = 0 that cycle.
  - cdb_valid <= 0 at the next edge, which also kills a packet captured in the previous cycle from broadcasting a second cycle. The packet captured in the previous cycle still broadcasts for its single cycle.
  - rr_ptr holds.
  - Requesters keep their results; the arbiter does not drain them.
- Simultaneous events:
  - All NUM_FU valid: requests are granted in the order rr_ptr, rr_ptr+1, … with wrap-around.
  - A requester newly raising valid in the same cycle another is granted waits its round-robin turn.
- Reset mid-broadcast: cdb_valid drops immediately (asynchronously). The pending packet is lost, and the ROB is reset concurrently.
- X safety: the fu_packet of non-granted or invalid requesters must not affect any output.

Optional Feature:
- Macro: CDB_MEM_PRIORITY_EN.
- Defined:
  - Any valid requester whose fu_packet.from_memory = 1 wins over round-robin order.
  - Among several memory requesters, the round-robin scan from rr_ptr decides.
  - rr_ptr still updates to g+1.
- Undefined: pure round-robin, and from_memory is ignored for arbitration.

Test Plan:
- Reset sequence: hold reset_n=0 with fu_valid=4'b1111 → fu_yumi=0, cdb_valid=0, cdb_out=0. Release reset → first grant is FU0.
- Single requester: fu_valid=4'b0100 with packet {rob=5, result=32'd10} → fu_yumi=4'b0100 that cycle, then cdb_valid=1 with rob=5, result=10 for one cycle. rr_ptr becomes 3.
- Round-robin fairness: all four valid and held until yumi'd, rr_ptr=0 → grants FU0, FU1, FU2, FU3 on consecutive cycles. cdb_valid high for 4 consecutive cycles, then low.
- Wrap-around: rr_ptr=3, fu_valid=4'b1001 → grant FU3, then FU0 next cycle.
- Flush: grant FU1 in cycle N, assert flush in cycle N+1 with FU2 valid → fu_yumi=0 in N+1, FU1's packet broadcasts in N+1, cdb_valid=0 in N+2, FU2 is granted in N+2 once flush drops.
- CDB_MEM_PRIORITY_EN defined: rr_ptr=0, FU0 (ALU) and FU3 (from_memory=1) both valid → FU3 granted first, then FU0. Undefined: FU0 first.
